branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 91 +++++++++
 tb/tb_branch_predictor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direction predictor: 2-bit counter table, bimodal or gshare indexing.
// Resolves at execute train the table and the global history.
module branch_predictor #(
  parameter int INDEX_BITS   = 6,
  parameter int HISTORY_BITS = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           pc_fetch,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  input  logic                  resolve_valid,
  input  logic [INDEX_BITS-1:0] resolve_index,
  input  logic [2:0]            resolve_funct3,
  input  logic                  result_equal_zero,
  input  logic                  resolve_predicted,
  output logic                  take_branch,
  output logic                  mispredict,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [1:0]            ctr [DEPTH];
  logic [INDEX_BITS-1:0] hist_ext;
  logic                  resolve_ok;
  logic                  unused_pc;

  assign unused_pc = ^{pc_fetch[31:INDEX_BITS+2], pc_fetch[1:0]};

  assign predict_index = pc_fetch[INDEX_BITS+1:2] ^ hist_ext;
  assign predict_taken = ctr[predict_index][1];

  // funct3 010/011 are not branch encodings
  assign resolve_ok = resolve_valid &&
                      (resolve_funct3[2:1] != 2'b01);

  always_comb begin
    take_branch = 1'b0;
    unique case (resolve_funct3)
      3'b000, 3'b101, 3'b111: take_branch = result_equal_zero;
      3'b001, 3'b100, 3'b110: take_branch = ~result_equal_zero;
      default:                take_branch = 1'b0;
    endcase
  end

  assign mispredict = resolve_ok &&
                      (take_branch != resolve_predicted);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        ctr[i] <= 2'b01;
    end else if (resolve_ok) begin
      if (take_branch && ctr[resolve_index] != 2'b11)
        ctr[resolve_index] <= ctr[resolve_index] + 2'b01;
      else if (!take_branch && ctr[resolve_index] != 2'b00)
        ctr[resolve_index] <= ctr[resolve_index] - 2'b01;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve_ok) begin
      branch_count <= branch_count + 32'd1;
      if (mispredict)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

  generate
    if (HISTORY_BITS > 0) begin : g_hist
      logic [HISTORY_BITS-1:0] history;

      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          history <= '0;
        else if (resolve_ok)
          history <= HISTORY_BITS'({history, take_branch});
      end

      assign hist_ext = INDEX_BITS'(history);
    end else begin : g_bimodal
      assign hist_ext = '0;
    end
  endgenerate

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal default plus a
// gshare instance (HISTORY_BITS=2) sharing the same stimulus.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_fetch;
  logic        resolve_valid;
  logic [5:0]  resolve_index;
  logic [2:0]  resolve_funct3;
  logic        result_equal_zero;
  logic        resolve_predicted;

  logic        predict_taken,    g_predict_taken;
  logic [5:0]  predict_index,    g_predict_index;
  logic        take_branch,      g_take_branch;
  logic        mispredict,       g_mispredict;
  logic [31:0] branch_count,     g_branch_count;
  logic [31:0] mispredict_count, g_mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock(clock), .reset(reset), .pc_fetch(pc_fetch),
    .predict_taken(predict_taken), .predict_index(predict_index),
    .resolve_valid(resolve_valid), .resolve_index(resolve_index),
    .resolve_funct3(resolve_funct3),
    .result_equal_zero(result_equal_zero),
    .resolve_predicted(resolve_predicted),
    .take_branch(take_branch), .mispredict(mispredict),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_predictor #(.INDEX_BITS(6), .HISTORY_BITS(2)) dut_g (
    .clock(clock), .reset(reset), .pc_fetch(pc_fetch),
    .predict_taken(g_predict_taken), .predict_index(g_predict_index),
    .resolve_valid(resolve_valid), .resolve_index(resolve_index),
    .resolve_funct3(resolve_funct3),
    .result_equal_zero(result_equal_zero),
    .resolve_predicted(resolve_predicted),
    .take_branch(g_take_branch), .mispredict(g_mispredict),
    .branch_count(g_branch_count),
    .mispredict_count(g_mispredict_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] idx,
                       input logic [2:0] f3, input logic rez,
                       input logic pred);
    resolve_valid     = v;
    resolve_index     = idx;
    resolve_funct3    = f3;
    result_equal_zero = rez;
    resolve_predicted = pred;
  endtask

  // expected state for index 5 walk, one entry per resolve
  logic [0:3] up_pt_before = 4'b0111;
  logic [0:3] dn_pt_before = 4'b1100;
  logic [0:3] dn_mp        = 4'b1100;
  logic [0:3] dn_pt_after  = 4'b1000;
  int         dn_mc [4]    = '{2, 3, 3, 3};

  initial begin
    reset    = 1'b1;
    pc_fetch = 32'h40;
    drive(1'b0, 6'd0, 3'b000, 1'b0, 1'b0);
    #2;
    check("rst_index", predict_index, 32'h10);
    check("rst_pt", predict_taken, 0);
    check("rst_bc", branch_count, 0);
    check("rst_mc", mispredict_count, 0);

    // resolves during reset must be ignored
    pc_fetch = 32'h14;
    drive(1'b1, 6'd5, 3'b000, 1'b1, 1'b0);
    edge_step();
    edge_step();
    reset = 1'b0;
    drive(1'b0, 6'd5, 3'b000, 1'b1, 1'b0);
    #1;
    check("rst_ign_pt", predict_taken, 0);
    check("rst_ign_bc", branch_count, 0);
    check("idle_mp", mispredict, 0);

    // three taken resolves: 01 -> 10 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd5, 3'b000, 1'b1, up_pt_before[i]);
      #1;
      check($sformatf("up%0d_pt_pre", i), predict_taken, up_pt_before[i]);
      check($sformatf("up%0d_tb", i), take_branch, 1);
      check($sformatf("up%0d_mp", i), mispredict, (i == 0) ? 1 : 0);
      edge_step();
      check($sformatf("up%0d_pt", i), predict_taken, 1);
      check($sformatf("up%0d_bc", i), branch_count, i + 1);
      check($sformatf("up%0d_mc", i), mispredict_count, 1);
    end

    // four not-taken (bne, equal): 11 -> 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'd5, 3'b001, 1'b1, dn_pt_before[i]);
      #1;
      check($sformatf("dn%0d_pt_pre", i), predict_taken, dn_pt_before[i]);
      check($sformatf("dn%0d_tb", i), take_branch, 0);
      check($sformatf("dn%0d_mp", i), mispredict, dn_mp[i]);
      edge_step();
      check($sformatf("dn%0d_pt", i), predict_taken, dn_pt_after[i]);
      check($sformatf("dn%0d_bc", i), branch_count, 4 + i);
      check($sformatf("dn%0d_mc", i), mispredict_count, dn_mc[i]);
    end

    // remaining funct3 decodes, resolve_valid low
    drive(1'b0, 6'd5, 3'b100, 1'b0, 1'b0); #1;
    check("blt_tb", take_branch, 1);
    check("blt_mp_inv", mispredict, 0);
    drive(1'b0, 6'd5, 3'b101, 1'b0, 1'b0); #1;
    check("bge_tb", take_branch, 0);
    drive(1'b0, 6'd5, 3'b110, 1'b1, 1'b0); #1;
    check("bltu_tb", take_branch, 0);
    drive(1'b0, 6'd5, 3'b111, 1'b1, 1'b0); #1;
    check("bgeu_tb", take_branch, 1);
    drive(1'b0, 6'd5, 3'b011, 1'b1, 1'b0); #1;
    check("f011_tb", take_branch, 0);
    edge_step();

    // funct3 010 with valid high: no effect
    drive(1'b1, 6'd5, 3'b010, 1'b1, 1'b1);
    #1;
    check("f010_tb", take_branch, 0);
    check("f010_mp", mispredict, 0);
    edge_step();
    check("f010_bc", branch_count, 7);
    check("f010_mc", mispredict_count, 3);
    check("f010_pt", predict_taken, 0);

    // from 00: taken twice gives 01 then 10
    drive(1'b1, 6'd5, 3'b000, 1'b1, 1'b0);
    edge_step();
    check("sat_pt1", predict_taken, 0);
    edge_step();
    check("sat_pt2", predict_taken, 1);
    check("sat_bc", branch_count, 9);
    check("sat_mc", mispredict_count, 5);

    // same-cycle update on predicted index: old value first
    drive(1'b1, 6'd5, 3'b001, 1'b1, 1'b1);
    #1;
    check("byp_pre", predict_taken, 1);
    edge_step();
    check("byp_post", predict_taken, 0);
    check("byp_bc", branch_count, 10);

    // reset between edges clears everything at once
    drive(1'b1, 6'd5, 3'b000, 1'b1, 1'b0);
    edge_step();
    check("mid_pre_pt", predict_taken, 1);
    drive(1'b0, 6'd5, 3'b000, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_bc", branch_count, 0);
    check("mid_mc", mispredict_count, 0);
    check("mid_pt", predict_taken, 0);
    #1;
    reset = 1'b0;
    drive(1'b1, 6'd5, 3'b000, 1'b1, 1'b0);
    edge_step();
    check("post_rst_bc", branch_count, 1);
    check("post_rst_pt", predict_taken, 1);

    // gshare: two taken resolves -> history 11
    reset = 1'b1;
    #1;
    reset = 1'b0;
    pc_fetch = 32'h40;
    drive(1'b1, 6'd0, 3'b000, 1'b1, 1'b0);
    #1;
    check("gs_idx0", g_predict_index, 32'h10);
    edge_step();
    check("gs_idx1", g_predict_index, 32'h11);
    edge_step();
    drive(1'b0, 6'd0, 3'b000, 1'b1, 1'b0);
    #1;
    check("gs_idx2", g_predict_index, 32'h13);
    check("gs_pt", g_predict_taken, 0);
    check("bim_idx", predict_index, 32'h10);
    check("gs_bc", g_branch_count, 2);
    edge_step();
    check("gs_hold", g_predict_index, 32'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
